// File: rtl/lu_pkg.sv
// Shared types and sizing helpers for the LU row-memory arbiter.
package lu_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_LU   = 2'd1,
      OWN_HOST = 2'd2
   } lu_owner_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_W    = 2'd1,
      GNT_R    = 2'd2,
      GNT_H    = 2'd3
   } lu_gnt_e;

   function automatic int row_w(input int size, input int width);
      return size * 2 * width;
   endfunction

   function automatic int addr_w(input int size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

endpackage

// Complex element j of a row: {imag, real}, each WIDTH bits.
`define LU_ELEM(row, j, width) row[(j) * 2 * (width) +: 2 * (width)]

// File: rtl/lu_row_arbiter.sv
// Arbitrates one single-port row SRAM between LU write, LU read and host,
// with host anti-starvation and a one-cycle tagged read return.
module lu_row_arbiter
   import lu_pkg::*;
#(
   parameter int SIZE     = 16,
   parameter int WIDTH    = 64,
   parameter int MAX_WAIT = 8,
   localparam int AW      = addr_w(SIZE),
   localparam int ROW_W   = row_w(SIZE, WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             lu_rd_valid_i,
   input  logic [AW-1:0]    lu_rd_addr_i,
   output logic             lu_rd_ready_o,
   output logic [ROW_W-1:0] lu_row_o,
   output logic [AW-1:0]    lu_row_addr_o,
   output logic             lu_row_valid_o,
   input  logic             lu_wr_valid_i,
   input  logic [AW-1:0]    lu_wr_addr_i,
   input  logic [ROW_W-1:0] lu_wr_data_i,
   output logic             lu_wr_ready_o,
   input  logic             host_req_i,
   input  logic             host_we_i,
   input  logic [AW-1:0]    host_addr_i,
   input  logic [ROW_W-1:0] host_wdata_i,
   output logic             host_gnt_o,
   output logic [ROW_W-1:0] host_rdata_o,
   output logic             host_rvalid_o,
   output logic             mem_en_o,
   output logic             mem_we_o,
   output logic [AW-1:0]    mem_addr_o,
   output logic [ROW_W-1:0] mem_wdata_o,
   input  logic [ROW_W-1:0] mem_rdata_i
);

   localparam logic [7:0] MAX_WAIT_Q = 8'(MAX_WAIT);

   logic [7:0]    wait_q;
   lu_owner_e     tag_owner_r;
   logic [AW-1:0] tag_addr_r;
   lu_gnt_e       gnt_s;
   logic          force_h_s;

   assign force_h_s = host_req_i && (wait_q >= MAX_WAIT_Q);

   // Winner selection; a starved host jumps ahead of both LU ports.
   always_comb begin
      gnt_s = GNT_NONE;
      if (rst_i) begin
         gnt_s = GNT_NONE;
      end else if (force_h_s) begin
         gnt_s = GNT_H;
      end else if (lu_wr_valid_i) begin
         gnt_s = GNT_W;
      end else if (lu_rd_valid_i) begin
         gnt_s = GNT_R;
      end else if (host_req_i) begin
         gnt_s = GNT_H;
      end else begin
         gnt_s = GNT_NONE;
      end
   end

   // Handshakes and SRAM port driven from the winner.
   always_comb begin
      lu_wr_ready_o = 1'b0;
      lu_rd_ready_o = 1'b0;
      host_gnt_o    = 1'b0;
      mem_en_o      = 1'b0;
      mem_we_o      = 1'b0;
      mem_addr_o    = '0;
      mem_wdata_o   = '0;
      case (gnt_s)
         GNT_W: begin
            lu_wr_ready_o = 1'b1;
            mem_en_o      = 1'b1;
            mem_we_o      = 1'b1;
            mem_addr_o    = lu_wr_addr_i;
            mem_wdata_o   = lu_wr_data_i;
         end
         GNT_R: begin
            lu_rd_ready_o = 1'b1;
            mem_en_o      = 1'b1;
            mem_addr_o    = lu_rd_addr_i;
         end
         GNT_H: begin
            host_gnt_o  = 1'b1;
            mem_en_o    = 1'b1;
            mem_we_o    = host_we_i;
            mem_addr_o  = host_addr_i;
            mem_wdata_o = host_wdata_i;
         end
         default: begin
         end
      endcase
   end

   // Host starvation counter, saturating.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wait_q <= 8'd0;
      end else if (flush_i || (gnt_s == GNT_H)) begin
         wait_q <= 8'd0;
      end else if (host_req_i && (wait_q != 8'hFF)) begin
         wait_q <= wait_q + 8'd1;
      end
   end

   // Read-return tag; flush drops even a read granted in the flush cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tag_owner_r <= OWN_NONE;
         tag_addr_r  <= '0;
      end else if (flush_i) begin
         tag_owner_r <= OWN_NONE;
         tag_addr_r  <= '0;
      end else begin
         case (gnt_s)
            GNT_R: begin
               tag_owner_r <= OWN_LU;
               tag_addr_r  <= lu_rd_addr_i;
            end
            GNT_H: begin
               tag_owner_r <= host_we_i ? OWN_NONE : OWN_HOST;
               tag_addr_r  <= host_addr_i;
            end
            default: begin
               tag_owner_r <= OWN_NONE;
               tag_addr_r  <= '0;
            end
         endcase
      end
   end

   // SRAM data steered to the tagged owner only.
   always_comb begin
      lu_row_o       = '0;
      lu_row_addr_o  = '0;
      lu_row_valid_o = 1'b0;
      host_rdata_o   = '0;
      host_rvalid_o  = 1'b0;
      case (tag_owner_r)
         OWN_LU: begin
            lu_row_o       = mem_rdata_i;
            lu_row_addr_o  = tag_addr_r;
            lu_row_valid_o = 1'b1;
         end
         OWN_HOST: begin
            host_rdata_o  = mem_rdata_i;
            host_rvalid_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: doc/lu_row_arbiter.md
# lu_row_arbiter

Shares one single-port matrix-row SRAM between the LU engine and a host load/unload port. Each granted access is one full row of SIZE complex doubles. The block sits between the `lu` engine's row read/write ports and the row memory. It replaces the bench-side direct memory hookup, so the host can preload a matrix and drain it back while the engine runs. Arbitration is fixed priority with a host anti-starvation counter; read data returns with one cycle of latency, tagged to its requester.

## Interface
- SIZE, 16, matrix dimension; AW = $clog2(SIZE)
- WIDTH, 64, bits per real/imag part; ROW_W = SIZE*2*WIDTH, element j = {imag, real} at [j*2*WIDTH +: 2*WIDTH]
- MAX_WAIT, 8, host-wait cycles before a forced host grant (1..255)
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  synchronous clear of the starvation counter and any pending read return
- lu_rd_valid_i / lu_rd_addr_i / lu_rd_ready_o  in/in/out  1/AW/1  engine row-read request
- lu_row_o / lu_row_addr_o / lu_row_valid_o  out  ROW_W/AW/1  engine read return
- lu_wr_valid_i / lu_wr_addr_i / lu_wr_data_i / lu_wr_ready_o  in/in/in/out  1/AW/ROW_W/1  engine row write
- host_req_i / host_we_i / host_addr_i / host_wdata_i / host_gnt_o  in/in/in/in/out  1/1/AW/ROW_W/1  host access
- host_rdata_o / host_rvalid_o  out  ROW_W/1  host read return
- mem_en_o / mem_we_o / mem_addr_o / mem_wdata_o  out  1/1/AW/ROW_W  SRAM port
- mem_rdata_i  in  ROW_W  SRAM read data, valid the cycle after a read enable

## Operation
- Requesters: LU write (W), LU read (R), host (H). At most one grant per cycle, decided combinationally from the current requests.
- Normal priority: W > R > H.
- Starvation counter `wait_q` (8 bits):
  - Increments each cycle H is requesting and not granted.
  - Clears on any H grant.
  - When `wait_q >= MAX_WAIT`, H is granted ahead of W and R for that one cycle.
- Handshakes:
  - Accept = valid & ready (host: req & gnt).
  - Requesters hold address, data and we stable until accepted.
  - Each ready/gnt is asserted only in the cycle its own request is granted; it is never asserted while the requester is idle.
- On grant: `mem_en_o = 1`; `mem_we_o`, `mem_addr_o` and `mem_wdata_o` come from the winner. With no grant, `mem_en_o = 0` and the other mem outputs are 0.
- Read return:
  - Any granted read registers a tag: owner in {NONE, LU, HOST} plus the address.
  - Next cycle, `mem_rdata_i` passes combinationally to the owner's data output with its valid = 1. `lu_row_addr_o` carries the tagged address.
  - The non-owner's valid is 0 and its data is 0.
- Back-to-back grants are supported: a new grant in the same cycle as a return is legal.
- flush_i: clears `wait_q`, and the tag becomes NONE on the next edge. A return already due in the flush cycle is still delivered. Grants are unaffected.

## Timing
- Reset values: all ready/gnt/valid = 0, `mem_en_o = 0`, all data/addr outputs 0, tag NONE, `wait_q = 0`.
- Grant-to-return latency is exactly 1 cycle; sustained throughput is 1 access per cycle.
- Write then read of the same address in consecutive cycles returns the new data. The SRAM is write-first; the arbiter adds no bypass.
- Simultaneous W and H writes to the same address: W wins (unless starvation forces H), and the loser is serialized after it. The last granted write persists.
- Reset asserted mid-transaction: outputs drop asynchronously and any in-flight return is discarded. Requesters must re-issue.
- H worst-case wait is MAX_WAIT+1 cycles under continuous W/R traffic.

## Structure
- Package `lu_pkg`: ROW_W/AW helper functions, `lu_owner_e` {OWN_NONE, OWN_LU, OWN_HOST}, and a complex-element slice macro/function.
- No sub-module needed. Contents are the grant logic, the tag register and `wait_q`; the SRAM stays outside the block.

## Test plan
- Host preload: host writes rows 0..15 with row i element 0 = (i + j0), then reads row 5. Required: `host_gnt_o` on each write, and `host_rvalid_o` exactly one cycle after the read grant carrying the row-5 data.
- Priority: W, R and H all request in the same cycle with `wait_q = 0`. Required: grant order W, then R, then H in three consecutive cycles, with `lu_row_valid_o` in the cycle after R's grant.
- Starvation, MAX_WAIT=3: W and R request continuously while H requests a read of row 2. Required: H granted on its 4th waiting cycle and `wait_q` back to 0; W/R grants resume the next cycle.
- Read-after-write: LU writes row 7 = all (1.5 + j-2.0), then reads row 7 the next cycle. Required: `lu_row_o` equals the written row and `lu_row_addr_o = 7`.
- Reset mid-read: assert `rst_i` in the cycle after an LU read grant. Required: `lu_row_valid_o = 0` immediately, all outputs at reset values, and no spurious valid after `rst_i` deasserts.
- Flush: flush_i coincides with an H wait count of 2. Required: `wait_q = 0` next cycle, and the in-cycle return is still delivered.
